sfft_collector: RTL and testbench

SFFT_COLLECTOR -- requirements
Module: sfft_collector

---
 rtl/sfft_collector.sv | 157 +++++++++++++++
 tb/tb_sfft_collector.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sfft_collector.sv
// Collects per-channel bin frames from second_fft into ping-pong banks and
// holds one complete frame at a time for random-access readout.
module sfft_collector #(
  parameter int DATA_WIDTH = 80,
  parameter int NBIN       = 16,
  parameter int IDX_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [3:0]            s_k,
  input  logic [IDX_WIDTH-1:0]  s_index,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  frame_avail,
  output logic [IDX_WIDTH-1:0]  frame_index,
  input  logic                  rd_en,
  input  logic [3:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  frame_ack,
  output logic                  frame_err,
  output logic [15:0]           ok_count,
  output logic [15:0]           err_count
);

  localparam logic [1:0] W_FILL  = 2'd0;
  localparam logic [1:0] W_DROP  = 2'd1;
  localparam logic [1:0] W_STALL = 2'd2;
  localparam logic [3:0] K_LAST  = 4'(NBIN - 1);

  logic [DATA_WIDTH-1:0] mem_q [2][NBIN];

  logic [1:0]            state_q, state_d;
  logic [3:0]            exp_k_q, exp_k_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [IDX_WIDTH-1:0]  bidx_q [2];
  logic [IDX_WIDTH-1:0]  bidx_d [2];
  logic                  wr_sel_q, wr_sel_d;
  logic                  swap_q, swap_d;
  logic [1:0]            full_q, full_d;
  logic                  ready_q;
  logic                  err_q, err_d;
  logic [15:0]           ok_q, ok_d;
  logic [15:0]           errc_q, errc_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic rd_sel, wbank, accept, ack, beat_bad, wr_en;

  // While a swap is pending the write side already targets the bank about to
  // become the write bank, so beats arriving in that cycle are not lost.
  assign rd_sel   = ~wr_sel_q;
  assign wbank    = wr_sel_q ^ swap_q;
  assign accept   = s_valid & ready_q;
  assign ack      = frame_ack & full_q[rd_sel];
  assign beat_bad = (s_k != exp_k_q)
                  || ((exp_k_q != 4'd0) && (s_index != idx_q))
                  || (s_last != (s_k == K_LAST));
  assign wr_en    = accept && (state_q == W_FILL) && !beat_bad;

  always_comb begin
    state_d  = state_q;
    exp_k_d  = exp_k_q;
    idx_d    = idx_q;
    bidx_d   = bidx_q;
    wr_sel_d = wr_sel_q;
    swap_d   = 1'b0;
    full_d   = full_q;
    err_d    = 1'b0;
    ok_d     = ok_q;
    errc_d   = errc_q;

    if (ack) full_d[rd_sel] = 1'b0;
    if (swap_q) wr_sel_d = ~wr_sel_q;

    case (state_q)
      W_FILL: begin
        if (accept) begin
          if (beat_bad) begin
            err_d   = 1'b1;
            exp_k_d = 4'd0;
            if (errc_q != '1) errc_d = errc_q + 16'd1;
            state_d = s_last ? W_FILL : W_DROP;
          end else begin
            if (exp_k_q == 4'd0) idx_d = s_index;
            if (s_last) begin
              exp_k_d       = 4'd0;
              full_d[wbank] = 1'b1;
              bidx_d[wbank] = s_index;
              if (ok_q != '1) ok_d = ok_q + 16'd1;
              if (full_q[rd_sel] && !ack) state_d = W_STALL;
              else                        swap_d  = 1'b1;
            end else begin
              exp_k_d = exp_k_q + 4'd1;
            end
          end
        end
      end
      W_DROP: begin
        if (accept && s_last) begin
          state_d = W_FILL;
          exp_k_d = 4'd0;
        end
      end
      W_STALL: begin
        if (ack) begin
          state_d = W_FILL;
          swap_d  = 1'b1;
        end
      end
      default: state_d = W_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= W_FILL;
      exp_k_q   <= '0;
      idx_q     <= '0;
      bidx_q    <= '{default: '0};
      wr_sel_q  <= 1'b0;
      swap_q    <= 1'b0;
      full_q    <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      ok_q      <= '0;
      errc_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q  <= state_d;
      exp_k_q  <= exp_k_d;
      idx_q    <= idx_d;
      bidx_q   <= bidx_d;
      wr_sel_q <= wr_sel_d;
      swap_q   <= swap_d;
      full_q   <= full_d;
      ready_q  <= (state_d != W_STALL);
      err_q    <= err_d;
      ok_q     <= ok_d;
      errc_q   <= errc_d;
      if (rd_en) rd_data_q <= mem_q[rd_sel][rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wbank][s_k] <= s_data;
  end

  assign s_ready     = ready_q;
  assign frame_avail = full_q[rd_sel];
  assign frame_index = bidx_q[rd_sel];
  assign rd_data     = rd_data_q;
  assign frame_err   = err_q;
  assign ok_count    = ok_q;
  assign err_count   = errc_q;

endmodule

// File: tb/tb_sfft_collector.sv
// Directed bench for sfft_collector: clean frames, back-pressure, ack/last
// collision, sequence errors and mid-frame reset.
module tb_sfft_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [79:0] s_data;
  logic [3:0]  s_k;
  logic [6:0]  s_index;
  logic        s_valid, s_last, s_ready;
  logic        frame_avail;
  logic [6:0]  frame_index;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [79:0] rd_data;
  logic        frame_ack, frame_err;
  logic [15:0] ok_count, err_count;

  int n_chk  = 0;
  int n_pass = 0;
  int ea, en;

  sfft_collector #(.DATA_WIDTH(80), .NBIN(16), .IDX_WIDTH(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_k(s_k), .s_index(s_index),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .frame_avail(frame_avail), .frame_index(frame_index),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_ack(frame_ack), .frame_err(frame_err),
    .ok_count(ok_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [3:0] k, input logic [6:0] idx, input logic last,
                      input logic [79:0] d, input logic ack);
    check("beat_ready", s_ready, 1'b1);
    s_valid = 1'b1; s_k = k; s_index = idx; s_last = last; s_data = d; frame_ack = ack;
    tick();
    s_valid = 1'b0; s_last = 1'b0; frame_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] idx0, input logic [6:0] idx1, input int sw_k,
                            input int skip_k, input int last_k, input logic [79:0] base,
                            input logic ack_last, output int err_at, output int err_n);
    err_at = -1; err_n = 0;
    for (int k = 0; k <= last_k; k++) begin
      if (k == skip_k) continue;
      beat(4'(k), (k >= sw_k) ? idx1 : idx0, k == last_k, base + 80'(k), ack_last && (k == last_k));
      if (frame_err) begin
        err_n++;
        if (err_at < 0) err_at = k;
      end
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [79:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check(tag, rd_data, exp);
  endtask

  task automatic ack_frame();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_data = '0; s_k = '0; s_index = '0; s_valid = 1'b0; s_last = 1'b0;
    rd_en = 1'b0; rd_addr = '0; frame_ack = 1'b0;

    // reset state
    #12;
    check("rst_ready", s_ready, 1'b0);
    check("rst_avail", frame_avail, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_ok", ok_count, 16'd0);
    check("rst_errc", err_count, 16'd0);
    check("rst_rdata", rd_data, 80'd0);
    check("rst_findex", frame_index, 7'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", s_ready, 1'b1);

    // clean frame, index 5, data = k
    send_frame(7'd5, 7'd5, 99, -1, 15, 80'h0, 1'b0, ea, en);
    check("f1_no_err", en, 0);
    check("f1_avail_pending", frame_avail, 1'b0);
    check("f1_ok", ok_count, 16'd1);
    tick();
    check("f1_avail", frame_avail, 1'b1);
    check("f1_index", frame_index, 7'd5);
    rd("f1_rd3", 4'd3, 80'd3);
    rd_addr = 4'd4;
    tick();
    check("f1_rd_hold", rd_data, 80'd3);

    // second frame while first is held -> stall
    send_frame(7'd7, 7'd7, 99, -1, 15, 80'h100, 1'b0, ea, en);
    check("f2_ok", ok_count, 16'd2);
    check("f2_stall_ready", s_ready, 1'b0);
    check("f2_index_old", frame_index, 7'd5);
    s_valid = 1'b1; s_k = 4'd0; s_index = 7'd11; s_data = 80'hDEAD;
    tick();
    check("f3_first_blocked", s_ready, 1'b0);
    tick();
    check("f3_still_blocked", s_ready, 1'b0);
    s_valid = 1'b0;
    ack_frame();
    check("f2_ack_avail", frame_avail, 1'b0);
    check("f2_ack_ready", s_ready, 1'b1);
    tick();
    check("f2_avail", frame_avail, 1'b1);
    check("f2_index", frame_index, 7'd7);
    rd("f2_rd15", 4'd15, 80'h10F);
    rd("f2_rd0", 4'd0, 80'h100);

    // ack coincident with good last beat
    send_frame(7'd2, 7'd2, 99, -1, 15, 80'h200, 1'b1, ea, en);
    check("f4_avail_gap", frame_avail, 1'b0);
    check("f4_ready_e1", s_ready, 1'b1);
    tick();
    check("f4_avail", frame_avail, 1'b1);
    check("f4_index", frame_index, 7'd2);
    check("f4_ready_e2", s_ready, 1'b1);
    check("f4_ok", ok_count, 16'd3);
    rd("f4_rd6", 4'd6, 80'h206);
    ack_frame();
    check("f4_cleared", frame_avail, 1'b0);
    ack_frame();
    check("stray_ack_avail", frame_avail, 1'b0);
    check("stray_ack_ready", s_ready, 1'b1);

    // k = 7 skipped
    send_frame(7'd3, 7'd3, 99, 7, 15, 80'h0, 1'b0, ea, en);
    check("skip_err_at", ea, 8);
    check("skip_err_pulses", en, 1);
    check("skip_errc", err_count, 16'd1);
    tick();
    check("skip_avail", frame_avail, 1'b0);
    check("skip_ok", ok_count, 16'd3);

    // index changes 5 -> 6 at k = 4
    send_frame(7'd5, 7'd6, 4, -1, 15, 80'h0, 1'b0, ea, en);
    check("idx_err_at", ea, 4);
    check("idx_err_pulses", en, 1);
    check("idx_errc", err_count, 16'd2);
    tick();
    check("idx_avail", frame_avail, 1'b0);
    send_frame(7'd9, 7'd9, 99, -1, 15, 80'h300, 1'b0, ea, en);
    tick();
    check("f5_avail", frame_avail, 1'b1);
    check("f5_index", frame_index, 7'd9);
    check("f5_ok", ok_count, 16'd4);
    rd("f5_rd12", 4'd12, 80'h30C);
    ack_frame();

    // early last at k = 9
    send_frame(7'd1, 7'd1, 99, -1, 9, 80'h0, 1'b0, ea, en);
    check("early_err_at", ea, 9);
    check("early_errc", err_count, 16'd3);
    check("early_ready", s_ready, 1'b1);
    send_frame(7'd4, 7'd4, 99, -1, 15, 80'h400, 1'b0, ea, en);
    check("f6_no_err", en, 0);
    tick();
    check("f6_avail", frame_avail, 1'b1);
    check("f6_index", frame_index, 7'd4);
    check("f6_ok", ok_count, 16'd5);
    rd("f6_rd9", 4'd9, 80'h409);

    // reset at k = 10 with a frame held
    for (int k = 0; k < 10; k++) beat(4'(k), 7'd8, 1'b0, 80'(k), 1'b0);
    s_valid = 1'b1; s_k = 4'd10; s_index = 7'd8;
    #3 rst_n = 1'b0;
    #1;
    check("mrst_avail", frame_avail, 1'b0);
    check("mrst_ready", s_ready, 1'b0);
    check("mrst_ok", ok_count, 16'd0);
    check("mrst_errc", err_count, 16'd0);
    check("mrst_rdata", rd_data, 80'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    s_valid = 1'b0;
    tick();
    check("mrst_ready_rel", s_ready, 1'b1);
    check("mrst_avail_rel", frame_avail, 1'b0);
    send_frame(7'd1, 7'd1, 99, -1, 15, 80'h500, 1'b0, ea, en);
    tick();
    check("f7_avail", frame_avail, 1'b1);
    check("f7_index", frame_index, 7'd1);
    check("f7_ok", ok_count, 16'd1);
    rd("f7_rd15", 4'd15, 80'h50F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
